monolith_stream_top: RTL and testbench

//  Streaming front-end for the Monolith permutation core (monolith_hash).
//  - Accepts a frame of input words on a valid/ready (AXI-Stream style) slave port.
//  - Reduces each word modulo the Mersenne prime 2^WORD_W-1, packs the words into a STATE_N-lane state and runs the core.
//  - Emits the first OUT_N lanes of the result on a valid/ready master port with last.
//  - Replaces the fixed 16x31-bit free-running wrapper; adds backpressure, padding, a squeeze width and mod reduction.

---
 rtl/monolith_pkg.sv | 29 ++
 rtl/monolith_hash.sv | 83 ++++++++
 rtl/monolith_mersenne_reduce.sv | 27 ++
 rtl/monolith_stream_top.sv | 148 ++++++++++++++
 tb/tb_monolith_stream_top.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/monolith_pkg.sv
// Shared definitions for the Monolith streaming front-end.
// Holds the default field/lane geometry, the Mersenne prime for the default
// word width, the field-element and state types, the front-end FSM encoding
// and a counter-width helper that never returns zero.
package monolith_pkg;

  localparam int WORD_W_DEF  = 31;
  localparam int IN_W_DEF    = 32;
  localparam int STATE_N_DEF = 16;
  localparam int OUT_N_DEF   = 8;
  localparam int ROUNDS_DEF  = 4;

  localparam logic [WORD_W_DEF-1:0] P = {WORD_W_DEF{1'b1}};

  typedef logic [WORD_W_DEF-1:0] fe_t;
  typedef fe_t [STATE_N_DEF-1:0] state_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HASH  = 2'd1,
    DRAIN = 2'd2
  } fsm_t;

  // Counter width for a count of n items; at least 1 bit so n==1 still works.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/monolith_hash.sv
// Monolith permutation core. Iterative: one round per clock after start.
// Round r, lane i: x'[i] = x[i]^2 + x[i+1 mod N] + (r*N + i + 1)  (mod P).
// valid pulses for one cycle when state_out holds the permuted state.
// Ports:
//   clk        in   1             clock
//   reset      in   1             synchronous reset, active-high
//   start      in   1             load state_in and begin a permutation
//   state_in   in   N x WORD_W    input state
//   valid      out  1             one-cycle pulse, result ready
//   state_out  out  N x WORD_W    permuted state
module monolith_hash
  import monolith_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int STATE_N = STATE_N_DEF,
  parameter int ROUNDS  = ROUNDS_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [STATE_N-1:0][WORD_W-1:0]   state_in,
  output logic                             valid,
  output logic [STATE_N-1:0][WORD_W-1:0]   state_out
);

  localparam int RW = cnt_w(ROUNDS);
  localparam logic [WORD_W:0] P_EXT = {1'b0, {WORD_W{1'b1}}};
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS-1);

  logic [STATE_N-1:0][WORD_W-1:0] x;
  logic [STATE_N-1:0][WORD_W-1:0] x_nxt;
  logic [RW-1:0]                  rnd;
  logic                           run;

  // Operands are at most P, and their sum is below 2P, so one subtract suffices.
  function automatic logic [WORD_W-1:0] add_mod(input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b);
    logic [WORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= P_EXT) s = s - P_EXT;
    return WORD_W'(s);
  endfunction

  function automatic logic [WORD_W-1:0] sq_mod(input logic [WORD_W-1:0] a);
    logic [2*WORD_W-1:0] p;
    p = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, a};
    return add_mod(p[WORD_W-1:0], p[2*WORD_W-1:WORD_W]);
  endfunction

  always_comb begin
    x_nxt = '0;
    for (int i = 0; i < STATE_N; i++) begin
      x_nxt[i] = add_mod(add_mod(sq_mod(x[i]), x[(i+1) % STATE_N]),
                         WORD_W'(int'(rnd) * STATE_N + i + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x     <= '0;
      rnd   <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        x   <= state_in;
        rnd <= '0;
        run <= 1'b1;
      end else if (run) begin
        x   <= x_nxt;
        rnd <= rnd + RW'(1);
        if (rnd == RND_LAST) begin
          run   <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign state_out = x;

endmodule

// File: rtl/monolith_mersenne_reduce.sv
// Combinational single-level Mersenne fold of a raw stream word into a field
// element modulo P = 2^WORD_W-1.
// Ports:
//   x  in  IN_W    raw input word
//   y  out WORD_W  reduced value in [0, P-1]
module monolith_mersenne_reduce #(
  parameter int WORD_W = 31,
  parameter int IN_W   = 32
) (
  input  logic [IN_W-1:0]   x,
  output logic [WORD_W-1:0] y
);

  localparam logic [WORD_W:0] P_EXT = {1'b0, {WORD_W{1'b1}}};

  logic [WORD_W:0] t;
  logic [WORD_W:0] u;

  always_comb begin
    // 2^WORD_W == 1 (mod P), so the high part just adds onto the low part.
    t = {1'b0, x[WORD_W-1:0]} + (WORD_W+1)'(x[IN_W-1:WORD_W]);
    // One conditional subtract; also folds t == P down to 0.
    u = (t >= P_EXT) ? (t - P_EXT) : t;
    y = WORD_W'(u);
  end

endmodule

// File: rtl/monolith_stream_top.sv
// Streaming front-end for the Monolith permutation core. Collects a frame of
// raw words, reduces each mod P into a lane, zero-pads short frames, runs the
// core and streams the first OUT_N result lanes out with last on the final one.
//
//   state | meaning
//   FILL  | accepting input words into lanes (s_ready=1)
//   HASH  | core running, lanes frozen, waiting for core valid
//   DRAIN | emitting out_reg[0..OUT_N-1] on the master port
//
// Ports:
//   clk      in   1     clock
//   reset_n  in   1     synchronous reset, active-low
//   s_data   in   IN_W  raw input word
//   s_valid  in   1     input word valid
//   s_last   in   1     input word is last of frame
//   s_ready  out  1     input word accepted this cycle when valid
//   m_data   out  IN_W  output lane, zero-extended
//   m_valid  out  1     output word valid
//   m_last   out  1     output word is lane OUT_N-1
//   m_ready  in   1     downstream accepts output word
//   busy     out  1     high in HASH or DRAIN
module monolith_stream_top
  import monolith_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int STATE_N = STATE_N_DEF,
  parameter int OUT_N   = OUT_N_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_valid,
  input  logic            s_last,
  output logic            s_ready,
  output logic [IN_W-1:0] m_data,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic            busy
);

  localparam int IC_W = cnt_w(STATE_N);
  localparam int OC_W = cnt_w(OUT_N);
  localparam logic [IC_W-1:0] IN_LAST  = IC_W'(STATE_N-1);
  localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_N-1);

  fsm_t                           state;
  logic [IC_W-1:0]                in_cnt;
  logic [OC_W-1:0]                out_cnt;
  logic [OC_W-1:0]                out_nxt;
  logic [IC_W-1:0]                out_idx;
  logic [STATE_N-1:0][WORD_W-1:0] lanes;
  logic [STATE_N-1:0][WORD_W-1:0] out_reg;
  logic [STATE_N-1:0][WORD_W-1:0] core_out;
  logic [WORD_W-1:0]              word_red;
  logic                           hash_start;
  logic                           core_valid;

  monolith_mersenne_reduce #(
    .WORD_W (WORD_W),
    .IN_W   (IN_W)
  ) u_reduce (
    .x (s_data),
    .y (word_red)
  );

  monolith_hash #(
    .WORD_W  (WORD_W),
    .STATE_N (STATE_N)
  ) u_hash (
    .clk       (clk),
    .reset     (~reset_n),
    .start     (hash_start),
    .state_in  (lanes),
    .valid     (core_valid),
    .state_out (core_out)
  );

  assign out_nxt = out_cnt + OC_W'(1);
  assign out_idx = IC_W'(out_nxt);
  assign busy    = (state != FILL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FILL;
      in_cnt     <= '0;
      out_cnt    <= '0;
      lanes      <= '0;
      out_reg    <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      s_ready    <= 1'b0;
      hash_start <= 1'b0;
    end else begin
      hash_start <= 1'b0;
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            lanes[in_cnt] <= word_red;
            in_cnt        <= in_cnt + IC_W'(1);
            // A full state closes the frame even without s_last.
            if (in_cnt == IN_LAST || s_last) begin
              for (int i = 0; i < STATE_N; i++) begin
                if (i > int'(in_cnt)) lanes[i] <= '0;
              end
              s_ready    <= 1'b0;
              hash_start <= 1'b1;
              state      <= HASH;
            end
          end
        end
        HASH: begin
          if (core_valid) begin
            out_reg <= core_out;
            out_cnt <= '0;
            m_valid <= 1'b1;
            m_data  <= IN_W'(core_out[0]);
            m_last  <= (OUT_N == 1);
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              m_data  <= '0;
              out_cnt <= '0;
              in_cnt  <= '0;
              lanes   <= '0;
              s_ready <= 1'b1;
              state   <= FILL;
            end else begin
              out_cnt <= out_nxt;
              m_data  <= IN_W'(out_reg[out_idx]);
              m_last  <= (out_nxt == OUT_LAST);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_monolith_stream_top.sv
module tb_monolith_stream_top;

  localparam int OUT_N  = 8;
  localparam int ROUNDS = 4;
  localparam longint unsigned PR = 64'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;

  always #5 clk = ~clk;

  monolith_stream_top dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .busy    (busy)
  );

  typedef struct {
    int               n;
    bit               nolast;
    int               bp;
    logic [15:0][31:0] w;
    logic [15:0][30:0] lane;
  } frame_t;

  frame_t      tbl[8];
  logic [30:0] expo[OUT_N];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] reduce_ref(input logic [31:0] v);
    longint unsigned t;
    t = {32'b0, v} % PR;
    return 31'(t);
  endfunction

  task automatic run_model(input logic [15:0][30:0] lane_in);
    longint unsigned x[16];
    longint unsigned y[16];
    for (int i = 0; i < 16; i++) x[i] = {33'b0, lane_in[i]};
    for (int r = 0; r < ROUNDS; r++) begin
      for (int i = 0; i < 16; i++)
        y[i] = ((x[i] * x[i]) % PR + x[(i+1) % 16] + longint'(r*16 + i + 1)) % PR;
      for (int i = 0; i < 16; i++) x[i] = y[i];
    end
    for (int i = 0; i < OUT_N; i++) expo[i] = 31'(x[i]);
  endtask

  task automatic send_frame(input int f, input bit hold);
    int wc;
    for (int k = 0; k < tbl[f].n; k++) begin
      s_valid = 1'b1;
      s_data  = tbl[f].w[k];
      s_last  = (k == tbl[f].n - 1) && !tbl[f].nolast;
      wc = 0;
      while (!s_ready && wc < 200) begin
        @(negedge clk);
        wc++;
      end
      if (!s_ready) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: frame %0d word %0d not accepted", f, k);
      end
      @(negedge clk);
    end
    if (hold) begin
      s_data = tbl[f+1].w[0];
      s_last = 1'b0;
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
    end
    check($sformatf("hash_start_f%0d", f), dut.hash_start, 1);
    check($sformatf("s_ready_hash_f%0d", f), s_ready, 0);
    for (int i = 0; i < 16; i++)
      check($sformatf("lane_f%0d_%0d", f, i), dut.lanes[i], tbl[f].lane[i]);
  endtask

  task automatic collect(input int f, input int stop);
    int          got = 0;
    int          cyc = 0;
    int          c = 0;
    bit          stalled = 0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    logic [3:0]  pat = 4'b1001;
    run_model(tbl[f].lane);
    while (got < stop && cyc < 300) begin
      m_ready = (tbl[f].bp == 0) ? 1'b1 : pat[c % 4];
      check($sformatf("s_ready_busy_f%0d", f), s_ready, 0);
      if (m_valid) begin
        if (stalled) begin
          check($sformatf("hold_data_f%0d", f), m_data, prev_d);
          check($sformatf("hold_last_f%0d", f), m_last, prev_l);
        end
        if (m_ready) begin
          check($sformatf("m_data_f%0d_%0d", f, got), m_data, {33'b0, expo[got]});
          check($sformatf("m_last_f%0d_%0d", f, got), m_last, (got == OUT_N - 1));
          got++;
        end
        stalled = !m_ready;
        prev_d  = m_data;
        prev_l  = m_last;
        c++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < stop) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: frame %0d got %0d outputs required %0d", f, got, stop);
    end
    if (stop == OUT_N) begin
      check($sformatf("m_valid_after_f%0d", f), m_valid, 0);
      check($sformatf("s_ready_after_f%0d", f), s_ready, 1);
      check($sformatf("busy_after_f%0d", f), busy, 0);
    end
  endtask

  initial begin
    for (int f = 0; f < 8; f++) begin
      tbl[f].n = 16; tbl[f].nolast = 0; tbl[f].bp = 0;
      tbl[f].w = '0; tbl[f].lane = '0;
    end
    // Reduction corners, hand-folded.
    tbl[0].w[0] = 32'h7FFF_FFFF; tbl[0].w[1] = 32'hFFFF_FFFF;
    tbl[0].w[2] = 32'h8000_0000; tbl[0].w[3] = 32'h0000_0005;
    tbl[0].lane[0] = 31'd0; tbl[0].lane[1] = 31'd1;
    tbl[0].lane[2] = 31'd1; tbl[0].lane[3] = 31'd5;
    // Early last after three words.
    tbl[1].n = 3;
    tbl[1].w[0] = 32'd1; tbl[1].w[1] = 32'd2; tbl[1].w[2] = 32'd3;
    tbl[1].lane[0] = 31'd1; tbl[1].lane[1] = 31'd2; tbl[1].lane[2] = 31'd3;
    // Short frame drained under backpressure.
    tbl[2].n = 5; tbl[2].bp = 1;
    tbl[2].w[0] = 32'hFFFF_FFFE; tbl[2].lane[0] = 31'h0;
    tbl[2].w[1] = 32'h7FFF_FFFE; tbl[2].lane[1] = 31'h7FFF_FFFE;
    tbl[2].w[2] = 32'h1234_5678; tbl[2].lane[2] = 31'h1234_5678;
    tbl[2].w[3] = 32'h8000_0001; tbl[2].lane[3] = 31'h2;
    tbl[2].w[4] = 32'hDEAD_BEEF; tbl[2].lane[4] = 31'h5EAD_BEF0;
    // Full generated frames; frame 6 omits s_last.
    for (int f = 3; f < 7; f++) begin
      for (int i = 0; i < 16; i++) begin
        tbl[f].w[i]    = 32'(32'h9E37_79B9 * 32'(i + 1)) + 32'(32'h0123_4567 * 32'(f));
        tbl[f].lane[i] = reduce_ref(tbl[f].w[i]);
      end
    end
    tbl[6].nolast = 1;
    // Single-word frame.
    tbl[7].n = 1; tbl[7].w[0] = 32'hFFFF_FFFF; tbl[7].lane[0] = 31'd1;

    reset_n = 1'b0; s_valid = 1'b1; s_data = 32'h0000_1234; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_m_data", m_data, 0);
    end
    s_valid = 1'b0; s_data = '0; reset_n = 1'b1;
    @(negedge clk);
    check("s_ready_rise", s_ready, 1);
    check("idle_m_valid", m_valid, 0);

    send_frame(0, 0); collect(0, OUT_N);
    send_frame(1, 0); collect(1, OUT_N);
    send_frame(2, 0); collect(2, OUT_N);
    send_frame(3, 1); collect(3, OUT_N);
    send_frame(4, 0); collect(4, OUT_N);

    send_frame(5, 0); collect(5, 3);
    m_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_data", m_data, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_s_ready_rise", s_ready, 1);

    send_frame(6, 0); collect(6, OUT_N);
    send_frame(7, 0); collect(7, OUT_N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
